// File: rtl/hsv_pkg.sv
// hsv_pkg: shared field slices, hue/saturation constants, side-band struct and helpers for hsv_to_rgb
package hsv_pkg;
  localparam int LATENCY = 4;
  localparam int H_HI = 23;
  localparam int H_LO = 15;
  localparam int S_HI = 14;
  localparam int S_LO = 8;
  localparam int V_HI = 7;
  localparam int V_LO = 0;
  localparam int R_HI = 23;
  localparam int R_LO = 16;
  localparam int G_HI = 15;
  localparam int G_LO = 8;
  localparam int B_HI = 7;
  localparam int B_LO = 0;
  localparam logic [8:0] HUE_MAX = 9'd359;
  localparam logic [8:0] SECTOR_W = 9'd60;
  localparam logic [10:0] RECIP60 = 11'd1093;
  localparam logic [6:0] S_FULL = 7'd127;
  typedef struct packed {
    logic en;
    logic valid;
    logic [23:0] pass;
    logic [23:0] raw;
  } side_t;
  function automatic logic [8:0] clamp_hue(input logic [8:0] h);
    return h > HUE_MAX ? HUE_MAX : h;
  endfunction
  function automatic logic [7:0] eff_sat(input logic [6:0] s);
    return s == S_FULL ? 8'd128 : {1'b0, s};
  endfunction
endpackage

// File: rtl/hsv_sector_decode.sv
// hsv_sector_decode: clamped hue hc -> sector k (0..5), in-sector offset r (0..59), sector parity odd
module hsv_sector_decode
  import hsv_pkg::*;
(
  input  logic [8:0] hc,
  output logic [2:0] k,
  output logic [5:0] r,
  output logic       odd
);
  localparam logic [8:0] B1 = SECTOR_W;
  localparam logic [8:0] B2 = 9'(2 * SECTOR_W);
  localparam logic [8:0] B3 = 9'(3 * SECTOR_W);
  localparam logic [8:0] B4 = 9'(4 * SECTOR_W);
  localparam logic [8:0] B5 = 9'(5 * SECTOR_W);
  logic [8:0] base;
  always_comb begin
    k = hc >= B5 ? 3'd5 : hc >= B4 ? 3'd4 : hc >= B3 ? 3'd3 : hc >= B2 ? 3'd2 : hc >= B1 ? 3'd1 : 3'd0;
    base = hc >= B5 ? B5 : hc >= B4 ? B4 : hc >= B3 ? B3 : hc >= B2 ? B2 : hc >= B1 ? B1 : 9'd0;
    r = 6'(hc - base);
    odd = k[0];
  end
endmodule

// File: rtl/hsv_to_rgb.sv
// hsv_to_rgb: 4-stage HSV->RGB converter (clk, rst, en/bypass, valid_in, pixel_in, pass_in -> valid_out, pixel_out, pass_thru)
module hsv_to_rgb
  import hsv_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        valid_in,
  input  logic [23:0] pixel_in,
  input  logic [23:0] pass_in,
  output logic        valid_out,
  output logic [23:0] pixel_out,
  output logic [23:0] pass_thru
);
  logic [8:0] hc;
  logic [2:0] k0;
  logic [5:0] r0;
  logic odd0;
  side_t side [LATENCY-1];
  logic [7:0] v1, seff1;
  logic [2:0] k1;
  logic [5:0] r1;
  logic odd1;
  logic [7:0] c2, v2;
  logic [5:0] t2;
  logic [2:0] k2;
  logic [13:0] p3;
  logic [7:0] c3, m3;
  logic [2:0] k3;
  logic [7:0] x, rr, gg, bb;
  logic [23:0] rgb;
  assign hc = clamp_hue(pixel_in[H_HI:H_LO]);
  hsv_sector_decode u_dec (.hc(hc), .k(k0), .r(r0), .odd(odd0));
  always_comb begin
    x = 8'((24'(p3) * 24'(RECIP60)) >> 16);
    rr = (k3 == 3'd0 || k3 == 3'd5) ? c3 : (k3 == 3'd1 || k3 == 3'd4) ? x : 8'd0;
    gg = (k3 == 3'd1 || k3 == 3'd2) ? c3 : (k3 == 3'd0 || k3 == 3'd3) ? x : 8'd0;
    bb = (k3 == 3'd3 || k3 == 3'd4) ? c3 : (k3 == 3'd2 || k3 == 3'd5) ? x : 8'd0;
    rgb = '0;
    rgb[R_HI:R_LO] = rr + m3;
    rgb[G_HI:G_LO] = gg + m3;
    rgb[B_HI:B_LO] = bb + m3;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LATENCY - 1; i++) side[i] <= '0;
      v1 <= '0;
      seff1 <= '0;
      k1 <= '0;
      r1 <= '0;
      odd1 <= 1'b0;
      c2 <= '0;
      v2 <= '0;
      t2 <= '0;
      k2 <= '0;
      p3 <= '0;
      c3 <= '0;
      m3 <= '0;
      k3 <= '0;
      valid_out <= 1'b0;
      pixel_out <= '0;
      pass_thru <= '0;
    end else begin
      side[0] <= {en, valid_in, pass_in, pixel_in};
      for (int i = 1; i < LATENCY - 1; i++) side[i] <= side[i-1];
      v1 <= pixel_in[V_HI:V_LO];
      seff1 <= eff_sat(pixel_in[S_HI:S_LO]);
      k1 <= k0;
      r1 <= r0;
      odd1 <= odd0;
      c2 <= 8'((16'(v1) * 16'(seff1)) >> 7);
      t2 <= odd1 ? 6'(SECTOR_W) - r1 : r1;
      v2 <= v1;
      k2 <= k1;
      p3 <= 14'(c2) * 14'(t2);
      m3 <= v2 - c2;
      c3 <= c2;
      k3 <= k2;
      valid_out <= side[LATENCY-2].valid;
      pass_thru <= side[LATENCY-2].pass;
      pixel_out <= side[LATENCY-2].en ? rgb : side[LATENCY-2].raw;
    end
  end
endmodule

// File: tb/tb_hsv_to_rgb.sv
// tb_hsv_to_rgb: randomized and directed checks of hsv_to_rgb against an arithmetic reference model
module tb_hsv_to_rgb;
  logic clk = 1'b0;
  logic rst, en, valid_in;
  logic [23:0] pixel_in, pass_in;
  logic valid_out;
  logic [23:0] pixel_out, pass_thru;
  int n_vec = 0;
  int n_cmp = 0;
  int n_fail = 0;
  typedef struct {
    logic v;
    logic [23:0] px;
    logic [23:0] ps;
  } exp_t;
  exp_t q[$];
  exp_t e;
  always #5 clk = ~clk;
  hsv_to_rgb dut (
    .clk(clk), .rst(rst), .en(en), .valid_in(valid_in), .pixel_in(pixel_in), .pass_in(pass_in),
    .valid_out(valid_out), .pixel_out(pixel_out), .pass_thru(pass_thru)
  );
  function automatic logic [23:0] hsv(input int h, input int s, input int v);
    return {9'(h), 7'(s), 8'(v)};
  endfunction
  function automatic logic [23:0] rnd_px();
    return hsv(int'($urandom_range(0, 511)), int'($urandom_range(0, 127)), int'($urandom_range(0, 255)));
  endfunction
  function automatic logic [23:0] model(input logic [23:0] px, input logic on);
    int h, s, v, sf, k, r, c, t, x, m;
    int ch [3];
    if (!on) return px;
    h = int'(px[23:15]);
    s = int'(px[14:8]);
    v = int'(px[7:0]);
    if (h > 359) h = 359;
    sf = (s == 127) ? 128 : s;
    k = h / 60;
    r = h % 60;
    c = v * sf / 128;
    t = (k % 2 == 1) ? 60 - r : r;
    x = c * t * 1093 / 65536;
    m = v - c;
    case (k)
      0: ch = '{c, x, 0};
      1: ch = '{x, c, 0};
      2: ch = '{0, c, x};
      3: ch = '{0, x, c};
      4: ch = '{x, 0, c};
      default: ch = '{c, 0, x};
    endcase
    return {8'(ch[0] + m), 8'(ch[1] + m), 8'(ch[2] + m)};
  endfunction
  task automatic tick(input logic r, input logic vi, input logic e_in, input logic [23:0] px, input logic [23:0] ps);
    rst = r;
    valid_in = vi;
    en = e_in;
    pixel_in = px;
    pass_in = ps;
    @(posedge clk);
    #1;
    n_vec++;
    if (r) begin
      q.delete();
      repeat (4) q.push_back('{v: 1'b0, px: 24'd0, ps: 24'd0});
    end else begin
      q.push_back('{v: vi, px: model(px, e_in), ps: ps});
      if (q.size() > 4) void'(q.pop_front());
    end
    e = q[0];
  endtask
  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, 1'b1, 1'b1, rnd_px(), 24'hFFFFFF);
      n_cmp++;
      if (valid_out !== 1'b0 || pixel_out !== 24'd0 || pass_thru !== 24'd0) begin
        n_fail++;
        $display("FAIL reset[%0d]: got v=%b px=%h ps=%h want 0/000000/000000", i, valid_out, pixel_out, pass_thru);
      end
    end
  endtask
  task automatic test_latency();
    tick(1'b0, 1'b1, 1'b1, hsv(0, 127, 255), 24'h5A5A5A);
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (valid_out !== 1'b0) begin
        n_fail++;
        $display("FAIL latency_early[%0d]: valid_out=%b want 0", i, valid_out);
      end
      tick(1'b0, 1'b0, 1'b1, 24'd0, 24'd0);
    end
    n_cmp++;
    if (valid_out !== 1'b1 || pixel_out !== 24'hFF0000 || pass_thru !== 24'h5A5A5A) begin
      n_fail++;
      $display("FAIL latency: got v=%b px=%h ps=%h want 1/ff0000/5a5a5a", valid_out, pixel_out, pass_thru);
    end
  endtask
  task automatic test_colors();
    logic [23:0] tp [9];
    logic [23:0] te [9];
    tp = '{hsv(0, 127, 255), hsv(120, 127, 255), hsv(60, 127, 255), hsv(30, 127, 200), hsv(200, 0, 128),
           hsv(400, 127, 255), hsv(511, 127, 255), hsv(240, 127, 255), hsv(180, 127, 255)};
    te = '{24'hFF0000, 24'h00FF00, 24'hFFFF00, 24'hC86400, 24'h808080, 24'hFF0004, 24'hFF0004, 24'h0000FF, 24'h00FFFF};
    for (int i = 0; i < 12; i++) begin
      if (i < 9) tick(1'b0, 1'b1, 1'b1, tp[i], 24'(i));
      else tick(1'b0, 1'b0, 1'b1, 24'd0, 24'd0);
      if (i >= 3) begin
        n_cmp++;
        if (valid_out !== 1'b1 || pixel_out !== te[i-3] || pass_thru !== 24'(i - 3)) begin
          n_fail++;
          $display("FAIL color[%0d]: got v=%b px=%h ps=%h want 1/%h/%h", i - 3, valid_out, pixel_out, pass_thru, te[i-3], 24'(i - 3));
        end
      end
    end
  endtask
  task automatic test_bypass();
    tick(1'b0, 1'b1, 1'b0, 24'h123456, 24'hABCDEF);
    repeat (3) tick(1'b0, 1'b0, 1'b1, 24'd0, 24'd0);
    n_cmp++;
    if (valid_out !== 1'b1 || pixel_out !== 24'h123456 || pass_thru !== 24'hABCDEF) begin
      n_fail++;
      $display("FAIL bypass: got v=%b px=%h ps=%h want 1/123456/abcdef", valid_out, pixel_out, pass_thru);
    end
    for (int i = 0; i < 24; i++) begin
      tick(1'b0, 1'b1, i[0], rnd_px(), 24'($urandom));
      n_cmp++;
      if (valid_out !== e.v || $isunknown(pixel_out) || (e.v && (pixel_out !== e.px || pass_thru !== e.ps))) begin
        n_fail++;
        $display("FAIL en_toggle[%0d]: got v=%b px=%h ps=%h want %b/%h/%h", i, valid_out, pixel_out, pass_thru, e.v, e.px, e.ps);
      end
    end
  endtask
  task automatic test_back_to_back(input int n);
    logic vi;
    for (int i = 0; i < n + 4; i++) begin
      vi = (i < n) && ($urandom_range(0, 3) != 0);
      tick(1'b0, vi, 1'b1, rnd_px(), 24'($urandom));
      n_cmp++;
      if (valid_out !== e.v || $isunknown(pixel_out) || (e.v && (pixel_out !== e.px || pass_thru !== e.ps))) begin
        n_fail++;
        $display("FAIL stream[%0d]: got v=%b px=%h ps=%h want %b/%h/%h", i, valid_out, pixel_out, pass_thru, e.v, e.px, e.ps);
      end
    end
  endtask
  task automatic test_reset_mid();
    repeat (6) tick(1'b0, 1'b1, 1'b1, rnd_px(), 24'($urandom));
    tick(1'b1, 1'b1, 1'b1, rnd_px(), 24'($urandom));
    n_cmp++;
    if (valid_out !== 1'b0 || pixel_out !== 24'd0 || pass_thru !== 24'd0) begin
      n_fail++;
      $display("FAIL reset_mid: got v=%b px=%h ps=%h want 0/000000/000000", valid_out, pixel_out, pass_thru);
    end
    for (int i = 0; i < 12; i++) begin
      tick(1'b0, i < 8, 1'b1, rnd_px(), 24'($urandom));
      n_cmp++;
      if ((i < 3 && valid_out !== 1'b0) || valid_out !== e.v || $isunknown(pixel_out) ||
          (e.v && (pixel_out !== e.px || pass_thru !== e.ps))) begin
        n_fail++;
        $display("FAIL resume[%0d]: got v=%b px=%h ps=%h want %b/%h/%h", i, valid_out, pixel_out, pass_thru, e.v, e.px, e.ps);
      end
    end
  endtask
  initial begin
    test_reset();
    test_latency();
    test_colors();
    test_bypass();
    test_back_to_back(16);
    test_back_to_back(200);
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
